// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if
//   Groups the sequencer's instruction/memory handshake and the datapath
//   control strobes into one bundle.
//   master : the sequencer (drives strobes, status and debug state)
//   slave  : the datapath/memory side (drives instruction and mem_ready)
//   Signals: instruction, mem_ready, PCWrite, IRWrite, RegWrite, MemtoReg,
//            ALUsrc, MemWrite, MemRead, ALU_CC, illegal, instret, state
interface multicycle_ctrl_if #(
  parameter int INS_W    = 32,
  parameter int ALU_CC_W = 4,
  parameter int CNT_W    = 32
);
  logic [INS_W-1:0]    instruction;
  logic                mem_ready;
  logic                PCWrite;
  logic                IRWrite;
  logic                RegWrite;
  logic                MemtoReg;
  logic                ALUsrc;
  logic                MemWrite;
  logic                MemRead;
  logic [ALU_CC_W-1:0] ALU_CC;
  logic                illegal;
  logic [CNT_W-1:0]    instret;
  logic [2:0]          state;

  modport master (
    input  instruction, mem_ready,
    output PCWrite, IRWrite, RegWrite, MemtoReg, ALUsrc, MemWrite, MemRead,
           ALU_CC, illegal, instret, state
  );

  modport slave (
    output instruction, mem_ready,
    input  PCWrite, IRWrite, RegWrite, MemtoReg, ALUsrc, MemWrite, MemRead,
           ALU_CC, illegal, instret, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Multi-cycle control sequencer for an RV64I datapath subset
//   (add/sub/and/or/xor/slt, their immediate forms, ld, sd).
//   Steps FETCH -> DECODE -> EXEC -> (MEM) -> (WB) per instruction and
//   traps permanently (until reset) on any unsupported encoding.
//   Ports:
//     clk   : rising-edge clock
//     reset : synchronous, active-high
//     bus   : multicycle_ctrl_if.master (instruction/mem_ready in,
//             control strobes, illegal, instret, state out)
module multicycle_ctrl #(
  parameter int INS_W    = 32,
  parameter int ALU_CC_W = 4,
  parameter int CNT_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  multicycle_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [INS_W-1:0] ir_q, ir_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             illegal_q, illegal_d;
  // High for the one cycle following a reset edge. The sequencer idles in
  // FETCH with every strobe low so that no IRWrite appears while reset is
  // being released; outputs never look at the reset pin directly.
  logic             rst_hold_q;

  // Register-number and immediate fields are not needed for control.
  logic unused_ir;
  assign unused_ir = ^{ir_q[INS_W-1:32], ir_q[24:15], ir_q[11:7]};

  // ---------------- decode of the latched instruction ----------------
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       f3_ok;
  logic [3:0] f3_code;
  logic       is_ld, is_sd, legal, alusrc_dec;
  logic [3:0] alu_cc_dec;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign funct7 = ir_q[31:25];

  always_comb begin
    f3_ok   = 1'b1;
    f3_code = 4'b0000;
    case (funct3)
      3'b000:  f3_code = 4'b0010;  // add / addi
      3'b111:  f3_code = 4'b0000;  // and / andi
      3'b110:  f3_code = 4'b0001;  // or  / ori
      3'b100:  f3_code = 4'b0011;  // xor / xori
      3'b010:  f3_code = 4'b0111;  // slt / slti
      default: f3_ok   = 1'b0;
    endcase
  end

  always_comb begin
    legal      = 1'b0;
    is_ld      = 1'b0;
    is_sd      = 1'b0;
    alusrc_dec = 1'b0;
    alu_cc_dec = 4'b0000;
    case (opcode)
      7'b0110011: begin
        if (funct7 == 7'b0000000 && f3_ok) begin
          legal      = 1'b1;
          alu_cc_dec = f3_code;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          legal      = 1'b1;
          alu_cc_dec = 4'b0110;  // sub
        end
      end
      7'b0010011: begin
        // funct7 overlaps the immediate here, so it is not checked.
        legal      = f3_ok;
        alusrc_dec = 1'b1;
        alu_cc_dec = f3_code;
      end
      7'b0000011: begin
        is_ld      = (funct3 == 3'b011);
        legal      = is_ld;
        alusrc_dec = 1'b1;
        alu_cc_dec = 4'b0010;
      end
      7'b0100011: begin
        is_sd      = (funct3 == 3'b011);
        legal      = is_sd;
        alusrc_dec = 1'b1;
        alu_cc_dec = 4'b0010;
      end
      default: ;
    endcase
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    instret_d = instret_q;
    illegal_d = illegal_q;
    if (!rst_hold_q) begin
      case (state_q)
        S_FETCH: begin
          ir_d    = bus.instruction;
          state_d = S_DECODE;
        end
        S_DECODE: begin
          if (legal) begin
            state_d = S_EXEC;
          end else begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        end
        S_EXEC:   state_d = (is_ld || is_sd) ? S_MEM : S_WB;
        S_MEM: begin
          if (bus.mem_ready) begin
            if (is_sd) begin
              state_d   = S_FETCH;
              instret_d = instret_q + 1'b1;
            end else begin
              state_d = S_WB;
            end
          end
        end
        S_WB: begin
          instret_d = instret_q + 1'b1;
          state_d   = S_FETCH;
        end
        S_TRAP:   state_d = S_TRAP;
        default:  state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      ir_q       <= '0;
      instret_q  <= '0;
      illegal_q  <= 1'b0;
      rst_hold_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      instret_q  <= instret_d;
      illegal_q  <= illegal_d;
      rst_hold_q <= 1'b0;
    end
  end

  // ---------------- outputs ----------------
  logic in_exec_phase;
  assign in_exec_phase = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);

  always_comb begin
    bus.IRWrite  = (state_q == S_FETCH) && !rst_hold_q;
    bus.RegWrite = (state_q == S_WB);
    bus.MemtoReg = (state_q == S_WB) && is_ld;
    bus.MemRead  = (state_q == S_MEM) && is_ld;
    bus.MemWrite = (state_q == S_MEM) && is_sd;
    // A store retires in the very cycle memory reports done, so this is the
    // one strobe that must follow mem_ready within the cycle.
    bus.PCWrite  = (state_q == S_WB) || ((state_q == S_MEM) && is_sd && bus.mem_ready);
    bus.ALUsrc   = in_exec_phase && alusrc_dec;
    bus.ALU_CC   = in_exec_phase ? ALU_CC_W'(alu_cc_dec) : '0;
    bus.illegal  = illegal_q;
    bus.instret  = instret_q;
    bus.state    = state_q;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.INS_W(32), .ALU_CC_W(4), .CNT_W(32)) bus ();

  multicycle_ctrl #(.INS_W(32), .ALU_CC_W(4), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int unsigned model_instret = 0;

  // instruction classes of the reference model
  localparam int C_ILL = 0, C_RR = 1, C_RI = 2, C_LD = 3, C_SD = 4;

  typedef enum int {PH_F, PH_D, PH_E, PH_M, PH_W, PH_T, PH_H} ph_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ALU operation table by mnemonic-funct3 (add, and, or, xor, slt).
  function automatic bit f3_lookup(input logic [2:0] f3, output logic [3:0] cc);
    logic [2:0] f3s [5] = '{3'b000, 3'b111, 3'b110, 3'b100, 3'b010};
    logic [3:0] ccs [5] = '{4'b0010, 4'b0000, 4'b0001, 4'b0011, 4'b0111};
    cc = 4'b0000;
    for (int i = 0; i < 5; i++)
      if (f3s[i] == f3) begin
        cc = ccs[i];
        return 1'b1;
      end
    return 1'b0;
  endfunction

  function automatic void classify(input logic [31:0] ins, output int cls, output logic [3:0] cc);
    logic [3:0] c;
    bit ok;
    cls = C_ILL;
    cc  = 4'b0000;
    ok  = f3_lookup(ins[14:12], c);
    if (ins[6:0] == 7'b0110011) begin
      if (ins[31:25] == 7'b0000000 && ok) begin cls = C_RR; cc = c; end
      else if (ins[31:25] == 7'b0100000 && ins[14:12] == 3'b000) begin cls = C_RR; cc = 4'b0110; end
    end else if (ins[6:0] == 7'b0010011 && ok) begin
      cls = C_RI; cc = c;
    end else if (ins[6:0] == 7'b0000011 && ins[14:12] == 3'b011) begin
      cls = C_LD; cc = 4'b0010;
    end else if (ins[6:0] == 7'b0100011 && ins[14:12] == 3'b011) begin
      cls = C_SD; cc = 4'b0010;
    end
  endfunction

  // Expected {state, IRWrite, PCWrite, RegWrite, MemtoReg, MemWrite, MemRead, ALUsrc, ALU_CC, illegal}
  function automatic logic [14:0] expv(input ph_t ph, input int cls, input logic [3:0] cc, input logic mr);
    logic [2:0] st = 3'd0;
    logic irw = 0, pcw = 0, rw = 0, m2r = 0, mw = 0, mrd = 0, asrc = 0, ill = 0;
    logic [3:0] c = 4'b0000;
    case (ph)
      PH_F: begin st = 3'd0; irw = 1; end
      PH_D: st = 3'd1;
      PH_E: st = 3'd2;
      PH_M: begin
        st  = 3'd3;
        mrd = (cls == C_LD);
        mw  = (cls == C_SD);
        pcw = (cls == C_SD) && mr;
      end
      PH_W: begin st = 3'd4; rw = 1; pcw = 1; m2r = (cls == C_LD); end
      PH_T: begin st = 3'd5; ill = 1; end
      default: st = 3'd0;
    endcase
    if (ph == PH_E || ph == PH_M || ph == PH_W) begin
      asrc = (cls != C_RR);
      c    = cc;
    end
    return {st, irw, pcw, rw, m2r, mw, mrd, asrc, c, ill};
  endfunction

  function automatic logic [14:0] obsv();
    return {bus.state, bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemtoReg,
            bus.MemWrite, bus.MemRead, bus.ALUsrc, bus.ALU_CC, bus.illegal};
  endfunction

  // One cycle: drive mem_ready for this cycle, then sample mid-cycle.
  task automatic step(input ph_t ph, input int cls, input logic [3:0] cc,
                      input logic mr, input string tag);
    @(negedge clk);
    bus.mem_ready = mr;
    #1;
    check(tag, {17'd0, obsv()}, {17'd0, expv(ph, cls, cc, mr)});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_instret = 0;
    #1;
    check("reset_vec", {17'd0, obsv()}, {17'd0, expv(PH_H, C_ILL, 4'd0, 1'b0)});
    check("reset_instret", bus.instret, 32'd0);
  endtask

  task automatic run_instr(input logic [31:0] ins, input int waits);
    int cls;
    logic [3:0] cc;
    int cycles = 0;
    classify(ins, cls, cc);
    bus.instruction = ins;
    step(PH_F, cls, cc, 1'($urandom), "fetch"); cycles++;
    step(PH_D, cls, cc, 1'($urandom), "decode"); cycles++;
    if (cls == C_ILL) begin
      for (int i = 0; i < 20; i++) begin
        step(PH_T, cls, cc, 1'($urandom), "trap"); cycles++;
      end
    end else begin
      step(PH_E, cls, cc, 1'($urandom), "exec"); cycles++;
      if (cls == C_LD || cls == C_SD)
        for (int w = 0; w <= waits; w++) begin
          step(PH_M, cls, cc, (w == waits), "mem"); cycles++;
        end
      if (cls != C_SD) begin
        step(PH_W, cls, cc, 1'($urandom), "wb"); cycles++;
      end
      model_instret++;
    end
    @(posedge clk);
    #1;
    check("instret", bus.instret, model_instret);
    $display("txn ins=%08h cls=%0d alu_cc=%b waits=%0d cycles=%0d instret=%0d",
             ins, cls, cc, waits, cycles, model_instret);
  endtask

  function automatic logic [31:0] rand_legal();
    logic [4:0] rd = 5'($urandom), rs1 = 5'($urandom), rs2 = 5'($urandom);
    logic [11:0] imm = 12'($urandom);
    logic [2:0] f3s [5] = '{3'b000, 3'b111, 3'b110, 3'b100, 3'b010};
    logic [2:0] f3 = f3s[$urandom_range(0, 4)];
    case ($urandom_range(1, 5))
      1: return {7'b0000000, rs2, rs1, f3, rd, 7'b0110011};
      2: return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
      3: return {imm, rs1, f3, rd, 7'b0010011};
      4: return {imm, rs1, 3'b011, rd, 7'b0000011};
      default: return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
    endcase
  endfunction

  initial begin
    int cls;
    logic [3:0] cc;
    logic [31:0] w;
    reset = 1'b1;
    bus.instruction = 32'd0;
    bus.mem_ready = 1'b0;

    do_reset();
    run_instr(32'h002081B3, 0);   // add x3,x1,x2
    run_instr(32'h0080B283, 3);   // ld x5,8(x1), 3 wait cycles
    run_instr(32'h0050B823, 0);   // sd x5,16(x1), immediate ready
    run_instr(32'h402081B3, 0);   // sub
    run_instr(32'h0020A193, 0);   // slti
    for (int i = 0; i < 30; i++)
      run_instr(rand_legal(), $urandom_range(0, 3));
    run_instr(32'hFFFFFFFF, 0);   // trap
    do_reset();

    // raw random words: mostly illegal, each trap cleared by reset
    for (int i = 0; i < 8; i++) begin
      w = $urandom;
      classify(w, cls, cc);
      run_instr(w, $urandom_range(0, 2));
      if (cls == C_ILL) do_reset();
    end

    // reset while an ld waits in MEM
    do_reset();
    run_instr(32'h002081B3, 0);
    w = 32'h0080B283;
    classify(w, cls, cc);
    bus.instruction = w;
    step(PH_F, cls, cc, 1'b0, "abort_fetch");
    step(PH_D, cls, cc, 1'b0, "abort_decode");
    step(PH_E, cls, cc, 1'b0, "abort_exec");
    step(PH_M, cls, cc, 1'b0, "abort_mem0");
    step(PH_M, cls, cc, 1'b0, "abort_mem1");
    @(negedge clk);
    reset = 1'b1;
    bus.mem_ready = 1'b0;
    #1;
    check("abort_pre_edge", {17'd0, obsv()}, {17'd0, expv(PH_M, cls, cc, 1'b0)});
    @(negedge clk);
    reset = 1'b0;
    model_instret = 0;
    #1;
    check("abort_vec", {17'd0, obsv()}, {17'd0, expv(PH_H, C_ILL, 4'd0, 1'b0)});
    check("abort_instret", bus.instret, 32'd0);
    $display("txn ins=%08h aborted by reset in MEM", w);
    run_instr(32'h0050B823, 1);
    run_instr(32'h0020A193, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
